seq_mult_core: RTL and testbench

- Parametrised shift-add multiplier: control FSM and datapath (A, B, X, M registers) in one block.
- Successor to the fixed 8-bit lab multiplier controller. Adds WIDTH generalisation, a counter-based sequencer in place of unrolled states, a run-time signed/unsigned mode and a busy/done handshake.
- Sits between the switch/button synchronisers and the hex-display drivers of the top level.

---
 rtl/seq_mult_core.sv | 126 ++++++++++++
 tb/tb_seq_mult_core.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_core.sv
// Sequential shift-add multiplier: control FSM plus A/B/X/M datapath.
// Unsigned or two's-complement operands selected per operation; product is {A,B}.
module seq_mult_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Run,
  input  logic               ClearA_LoadB,
  input  logic               Signed_Mode,
  input  logic [WIDTH-1:0]   Din,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Aval,
  output logic [WIDTH-1:0]   Bval,
  output logic               X,
  output logic [2*WIDTH-1:0] Product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAdd,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             x_q, x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;

  logic [WIDTH:0]   a_ext, m_ext, sum;
  logic             last_bit;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // The signed multiplier's MSB carries negative weight, so its step subtracts.
  always_comb begin
    last_bit = (cnt_q == LastCnt);
    a_ext    = mode_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
    m_ext    = mode_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
    sum      = (mode_q && last_bit) ? (a_ext - m_ext) : (a_ext + m_ext);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        if (Run) begin
          state_d = StStart;
        end else if (ClearA_LoadB) begin
          b_d = Din;
          a_d = '0;
          x_d = 1'b0;
        end
      end
      StStart: begin
        m_d     = Din;
        a_d     = '0;
        x_d     = 1'b0;
        cnt_d   = '0;
        mode_d  = Signed_Mode;
        state_d = StAdd;
      end
      StAdd: begin
        if (b_q[0]) begin
          a_d = sum[WIDTH-1:0];
          x_d = sum[WIDTH];
        end
        state_d = StShift;
      end
      StShift: begin
        x_d     = mode_q ? x_q : 1'b0;
        a_d     = {x_q, a_q[WIDTH-1:1]};
        b_d     = {a_q[0], b_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last_bit ? StDone : StAdd;
      end
      StDone: begin
        if (!Run) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign Busy    = (state_q == StStart) || (state_q == StAdd) || (state_q == StShift);
  assign Done    = (state_q == StDone);
  assign Aval    = a_q;
  assign Bval    = b_q;
  assign X       = x_q;
  assign Product = {a_q, b_q};

endmodule

// File: tb/tb_seq_mult_core.sv
// Scoreboard bench for seq_mult_core at WIDTH 8, 4 and 16.
// Stimulus pushes expected products; per-instance monitors pop them on each rising Done.
module tb_seq_mult_core;

  typedef struct {
    logic [31:0] prod;
    logic        x;
    bit          chkx;
    string       nm;
  } exp_t;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  exp_t q8[$];
  exp_t q4[$];
  exp_t q16[$];

  // WIDTH = 8 instance
  logic        run8, cl8, sgn8;
  logic [7:0]  din8;
  logic        busy8, done8, x8;
  logic [7:0]  aval8, bval8;
  logic [15:0] product8;

  // WIDTH = 4 instance
  logic        run4, cl4, sgn4;
  logic [3:0]  din4;
  logic        busy4, done4, x4;
  logic [3:0]  aval4, bval4;
  logic [7:0]  product4;

  // WIDTH = 16 instance
  logic        run16, cl16, sgn16;
  logic [15:0] din16;
  logic        busy16, done16, x16;
  logic [15:0] aval16, bval16;
  logic [31:0] product16;

  seq_mult_core #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset_n(rst_n), .Run(run8), .ClearA_LoadB(cl8), .Signed_Mode(sgn8),
    .Din(din8), .Busy(busy8), .Done(done8), .Aval(aval8), .Bval(bval8), .X(x8),
    .Product(product8)
  );

  seq_mult_core #(.WIDTH(4)) u_dut4 (
    .Clk(clk), .Reset_n(rst_n), .Run(run4), .ClearA_LoadB(cl4), .Signed_Mode(sgn4),
    .Din(din4), .Busy(busy4), .Done(done4), .Aval(aval4), .Bval(bval4), .X(x4),
    .Product(product4)
  );

  seq_mult_core #(.WIDTH(16)) u_dut16 (
    .Clk(clk), .Reset_n(rst_n), .Run(run16), .ClearA_LoadB(cl16), .Signed_Mode(sgn16),
    .Din(din16), .Busy(busy16), .Done(done16), .Aval(aval16), .Bval(bval16), .X(x16),
    .Product(product16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  task automatic score(input exp_t e, input logic [31:0] prod, input logic xv);
    check({e.nm, "_product"}, prod, e.prod);
    if (e.chkx) check({e.nm, "_x"}, {31'h0, xv}, {31'h0, e.x});
  endtask

  // Monitors: one pop per rising edge of Done.
  logic done8_prev = 1'b0, done4_prev = 1'b0, done16_prev = 1'b0;
  exp_t e8, e4, e16;

  always @(negedge clk) begin
    if (done8 && !done8_prev) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut8_unexpected_done actual=1 expected=0");
      end else begin
        e8 = q8.pop_front();
        score(e8, {16'h0, product8}, x8);
      end
    end
    done8_prev = done8;
  end

  always @(negedge clk) begin
    if (done4 && !done4_prev) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4_unexpected_done actual=1 expected=0");
      end else begin
        e4 = q4.pop_front();
        score(e4, {24'h0, product4}, x4);
      end
    end
    done4_prev = done4;
  end

  always @(negedge clk) begin
    if (done16 && !done16_prev) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut16_unexpected_done actual=1 expected=0");
      end else begin
        e16 = q16.pop_front();
        score(e16, product16, x16);
      end
    end
    done16_prev = done16;
  end

  task automatic load8(input logic [7:0] d);
    @(negedge clk); cl8 = 1'b1; din8 = d;
    @(negedge clk); cl8 = 1'b0;
  endtask

  task automatic mul8(input logic [7:0] m, input logic sgn, input logic [15:0] expp,
                      input logic expx, input bit chkx, input string nm,
                      input bit disturb, input bit with_clear, input int hold);
    int   n;
    exp_t e;
    @(negedge clk);
    din8 = m; sgn8 = sgn; run8 = 1'b1; cl8 = with_clear;
    e.prod = {16'h0, expp}; e.x = expx; e.chkx = chkx; e.nm = nm;
    q8.push_back(e);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) cl8 = 1'b0;
      if (disturb && n == 5) begin cl8 = 1'b1; din8 = 8'hAA; sgn8 = ~sgn; end
      if (disturb && n == 7) cl8 = 1'b0;
    end while (!done8 && n < 60);
    check({nm, "_latency"}, 32'(n), 32'd18);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, "_hold"}, {15'h0, done8, product8}, {15'h0, 1'b1, expp});
    end
    @(negedge clk); run8 = 1'b0;
    @(posedge clk); #1;
    check({nm, "_to_idle"}, {30'h0, done8, busy8}, 32'h0);
  endtask

  task automatic mul4(input logic [3:0] b, input logic [3:0] m, input logic sgn,
                      input logic [7:0] expp, input string nm);
    int   n;
    exp_t e;
    @(negedge clk); cl4 = 1'b1; din4 = b;
    @(negedge clk); cl4 = 1'b0; din4 = m; sgn4 = sgn; run4 = 1'b1;
    e.prod = {24'h0, expp}; e.x = 1'b0; e.chkx = 1'b0; e.nm = nm;
    q4.push_back(e);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!done4 && n < 60);
    check({nm, "_latency"}, 32'(n), 32'd10);
    @(negedge clk); run4 = 1'b0;
    @(posedge clk); #1;
    check({nm, "_to_idle"}, {30'h0, done4, busy4}, 32'h0);
  endtask

  task automatic mul16(input logic [15:0] b, input logic [15:0] m, input logic sgn,
                       input logic [31:0] expp, input string nm);
    int   n;
    exp_t e;
    @(negedge clk); cl16 = 1'b1; din16 = b;
    @(negedge clk); cl16 = 1'b0; din16 = m; sgn16 = sgn; run16 = 1'b1;
    e.prod = expp; e.x = 1'b0; e.chkx = 1'b1; e.nm = nm;
    q16.push_back(e);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!done16 && n < 100);
    check({nm, "_latency"}, 32'(n), 32'd34);
    @(negedge clk); run16 = 1'b0;
    @(posedge clk); #1;
    check({nm, "_to_idle"}, {30'h0, done16, busy16}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    run8 = 1'b0;  cl8 = 1'b0;  sgn8 = 1'b0;  din8 = '0;
    run4 = 1'b0;  cl4 = 1'b0;  sgn4 = 1'b0;  din4 = '0;
    run16 = 1'b0; cl16 = 1'b0; sgn16 = 1'b0; din16 = '0;
    #12;
    check("reset_dut8", {14'h0, busy8, done8, product8}, 32'h0);
    check("reset_dut4", {22'h0, busy4, done4, product4}, 32'h0);
    check("reset_dut16", {busy16, done16, product16[29:0]}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Unsigned 7*3, then a back-to-back run reusing B = 0x15 as the multiplier.
    load8(8'h07);
    mul8(8'h03, 1'b0, 16'h0015, 1'b0, 1'b1, "u_7x3", 1'b0, 1'b0, 0);
    mul8(8'h02, 1'b0, 16'h002A, 1'b0, 1'b1, "b2b_15x2", 1'b0, 1'b0, 0);

    load8(8'hFF);
    mul8(8'hFF, 1'b0, 16'hFE01, 1'b0, 1'b1, "u_ffxff", 1'b0, 1'b0, 0);
    load8(8'hFF);
    mul8(8'hFF, 1'b1, 16'h0001, 1'b0, 1'b0, "s_m1xm1", 1'b0, 1'b0, 0);
    load8(8'h80);
    mul8(8'h80, 1'b1, 16'h4000, 1'b0, 1'b0, "s_m128xm128", 1'b0, 1'b0, 0);
    load8(8'h02);
    mul8(8'hFD, 1'b1, 16'hFFFA, 1'b1, 1'b1, "s_2xm3", 1'b0, 1'b0, 0);
    load8(8'h80);
    mul8(8'h7F, 1'b1, 16'hC080, 1'b0, 1'b0, "s_m128x127", 1'b0, 1'b0, 0);

    // Inputs disturbed while busy must not matter.
    load8(8'h0C);
    mul8(8'h0B, 1'b0, 16'h0084, 1'b0, 1'b1, "busy_ignore", 1'b1, 1'b0, 0);
    // Run and ClearA_LoadB together: START wins, B stays 0x05.
    load8(8'h05);
    mul8(8'h03, 1'b0, 16'h000F, 1'b0, 1'b1, "run_over_clear", 1'b0, 1'b1, 0);
    // Run held past Done: stays in DONE with a stable product.
    load8(8'h10);
    mul8(8'h10, 1'b0, 16'h0100, 1'b0, 1'b1, "hold_done", 1'b0, 1'b0, 3);

    // Async reset during the 5th SHIFT (state entered on edge 11).
    load8(8'h33);
    @(negedge clk); din8 = 8'h44; sgn8 = 1'b0; run8 = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    check("midop_busy", {31'h0, busy8}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midop_reset", {14'h0, busy8, done8, product8}, 32'h0);
    @(negedge clk); run8 = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", {14'h0, busy8, done8, product8}, 32'h0);
    load8(8'h09);
    mul8(8'h09, 1'b1, 16'h0051, 1'b0, 1'b0, "post_reset_9x9", 1'b0, 1'b0, 0);

    mul4(4'h9, 4'h7, 1'b1, 8'hCF, "w4_m7x7");
    mul16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16_ffff");

    repeat (3) @(posedge clk);
    #1;
    check("q8_drained", 32'(q8.size()), 32'h0);
    check("q4_drained", 32'(q4.size()), 32'h0);
    check("q16_drained", 32'(q16.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
